// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter and its input synchroniser.
package clk_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser followed by a registered rising-edge pulse.
// o_level is delayed to line up with o_rise, so o_rise implies o_level.
module sync_edge_det
    import clk_period_meter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_level_d;
    logic                  r_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_DEPTH-2:0], i_sig};
            r_level_d <= r_sync[SYNC_DEPTH-1];
            r_rise    <= r_sync[SYNC_DEPTH-1] & ~r_level_d;
        end
    end

    assign o_level = r_level_d;
    assign o_rise  = r_rise;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rising-edge-to-rising-edge period of sig_in in clk cycles, tracks lock,
// and presents results on a one-entry valid/ready register. High-time capture is
// built only when PERIOD_METER_DUTY_EN is defined; otherwise meas_high reads 0.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             locked,
    output logic             no_signal,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam int               MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);

    logic               w_level;
    logic               w_rise;
    logic               w_sat;
    logic               w_emit;
    logic [CNT_W-1:0]   w_hi;
    logic [MATCH_W-1:0] w_match_next;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_prev;
    logic [MATCH_W-1:0] r_match;
    logic               r_locked;
    logic               r_no_signal;
    logic               r_valid;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high;

    sync_edge_det u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (sig_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    // cnt restarts at 1 on the rise cycle so a P-cycle period reads back as P.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (w_rise)
            r_cnt <= CNT_W'(1);
        else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + CNT_W'(1);
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] r_hi_cnt;

    // The rise cycle itself is high, hence the restart at 1.
    always_ff @(posedge clk) begin
        if (reset)
            r_hi_cnt <= '0;
        else if (w_rise)
            r_hi_cnt <= CNT_W'(1);
        else if (w_level && r_hi_cnt != CNT_MAX)
            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
    end

    assign w_hi = r_hi_cnt;
`else
    logic w_unused_level;
    assign w_unused_level = w_level;
    assign w_hi           = '0;
`endif

    assign w_sat  = (r_cnt == CNT_MAX);
    assign w_emit = w_rise && (r_state == RUN);

    always_comb begin
        w_match_next = MATCH_W'(1);
        if (r_cnt == r_prev)
            w_match_next = (r_match == MATCH_MAX) ? r_match : r_match + MATCH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prev      <= '0;
            r_match     <= '0;
            r_locked    <= 1'b0;
            r_no_signal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= RUN;
                    end else if (w_sat) begin
                        r_state     <= TIMEOUT;
                        r_no_signal <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_rise) begin
                        r_prev   <= r_cnt;
                        r_match  <= w_match_next;
                        r_locked <= (w_match_next == MATCH_MAX);
                    end else if (w_sat) begin
                        r_state     <= TIMEOUT;
                        r_no_signal <= 1'b1;
                        r_prev      <= '0;
                        r_match     <= '0;
                        r_locked    <= 1'b0;
                    end
                end
                TIMEOUT: begin
                    if (w_rise) begin
                        r_state     <= RUN;
                        r_no_signal <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A new result may replace the held one only if it is empty or leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_overrun <= 1'b0;
        end else if (w_emit && (!r_valid || meas_ready)) begin
            r_valid  <= 1'b1;
            r_period <= r_cnt;
            r_high   <= w_hi;
        end else if (w_emit) begin
            r_overrun <= 1'b1;
        end else if (r_valid && meas_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign meas_valid  = r_valid;
    assign meas_period = r_period;
    assign meas_high   = r_high;
    assign locked      = r_locked;
    assign no_signal   = r_no_signal;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: waveform generator plus a period-list reference model,
// directed handshake/timeout/reset scenarios and randomized period sequences.
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int LOCK  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             locked;
    logic             no_signal;
    logic             overrun;

    clk_period_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK)) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .locked      (locked),
        .no_signal   (no_signal),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int hi;
        bit lk;
    } meas_t;

    int    n_vec = 0;
    int    n_err = 0;
    meas_t exp_q[$];
    meas_t mon_m;
    bit    mon_en = 1'b0;
    bit    m_run;
    int    m_prev, m_match, p_per, p_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_high(input int h);
`ifdef PERIOD_METER_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_run   = 1'b0;
        m_prev  = 0;
        m_match = 0;
    endtask

    task automatic model_timeout();
        m_run   = 1'b0;
        m_match = 0;
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            sig_in = v;
        end
    endtask

    // One period starting with a rise; that rise closes the previous period if running.
    task automatic gen_period(input int hi, input int lo);
        meas_t m;
        if (m_run) begin
            m_match = (p_per == m_prev) ? ((m_match < LOCK) ? m_match + 1 : LOCK) : 1;
            m_prev  = p_per;
            m.per   = p_per;
            m.hi    = exp_high(p_hi);
            m.lk    = (m_match == LOCK);
            exp_q.push_back(m);
        end
        m_run = 1'b1;
        p_per = hi + lo;
        p_hi  = hi;
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        sig_in     = 1'b0;
        meas_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (mon_en && meas_valid && meas_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_meas", meas_period, 0);
            end else begin
                mon_m = exp_q.pop_front();
                $display("xfer period=%0d high=%0d locked=%0d", meas_period, meas_high, locked);
                chk("period", meas_period, mon_m.per);
                chk("high", meas_high, mon_m.hi);
                chk("locked", locked, mon_m.lk);
                chk("overrun", overrun, 0);
            end
        end
    end

    initial begin
        int p, reps, h;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", meas_valid, 0);
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        chk("rst_locked", locked, 0);
        chk("rst_no_signal", no_signal, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;

        // clk/4 with ready held high: lock on the 4th measurement
        model_reset();
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        repeat (6) gen_period(2, 2);
        gen_period(1, 3);
        drive(1'b0, 4);
        chk("t1_drain", exp_q.size(), 0);
        chk("t1_locked", locked, 1);
        chk("t1_overrun", overrun, 0);
        mon_en = 1'b0;

        // clk/16 with consumer stalled: hold, drop, then drain
        do_reset();
        drive(1'b1, 8); drive(1'b0, 8);
        drive(1'b1, 8); drive(1'b0, 8);
        chk("t2_valid", meas_valid, 1);
        chk("t2_period", meas_period, 16);
        chk("t2_high", meas_high, exp_high(8));
        chk("t2_overrun_clear", overrun, 0);
        drive(1'b1, 8); drive(1'b0, 8);
        chk("t2_held_valid", meas_valid, 1);
        chk("t2_held_period", meas_period, 16);
        chk("t2_overrun_set", overrun, 1);
        meas_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid_drop", meas_valid, 0);
        chk("t2_overrun_sticky", overrun, 1);
        meas_ready = 1'b0;

        // lock at 8, one stretched period of 10, then re-lock at 8
        do_reset();
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        repeat (5) gen_period(3, 5);
        gen_period(4, 6);
        repeat (5) gen_period(2, 6);
        gen_period(1, 3);
        drive(1'b0, 4);
        chk("t3_drain", exp_q.size(), 0);
        chk("t3_relocked", locked, 1);
        mon_en = 1'b0;

        // input stuck low until the counter saturates, then restart at clk/2
        do_reset();
        meas_ready = 1'b1;
        mon_en     = 1'b1;
        repeat (5) gen_period(2, 2);
        drive(1'b0, 200);
        chk("t4_no_signal_early", no_signal, 0);
        chk("t4_locked_before", locked, 1);
        drive(1'b0, 100);
        model_timeout();
        chk("t4_no_signal", no_signal, 1);
        chk("t4_locked_cleared", locked, 0);
        repeat (4) gen_period(1, 1);
        chk("t4_no_signal_clear", no_signal, 0);
        drive(1'b0, 4);
        chk("t4_drain", exp_q.size(), 0);
        mon_en = 1'b0;

        // single-cycle reset while holding a locked measurement
        do_reset();
        repeat (6) gen_period(2, 2);
        drive(1'b0, 2);
        chk("t5_pre_valid", meas_valid, 1);
        chk("t5_pre_locked", locked, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("t5_valid", meas_valid, 0);
        chk("t5_period", meas_period, 0);
        chk("t5_high", meas_high, 0);
        chk("t5_locked", locked, 0);
        chk("t5_no_signal", no_signal, 0);
        chk("t5_overrun", overrun, 0);
        drive(1'b0, 3);
        drive(1'b1, 2); drive(1'b0, 4);
        chk("t5_first_rise_silent", meas_valid, 0);
        drive(1'b1, 2); drive(1'b0, 4);
        chk("t5_second_valid", meas_valid, 1);
        chk("t5_second_period", meas_period, 6);

        // new measurement produced in the same cycle as a transfer
        do_reset();
        drive(1'b1, 3); drive(1'b0, 3);
        drive(1'b1, 3); drive(1'b0, 5);
        chk("t6_held_valid", meas_valid, 1);
        chk("t6_held_period", meas_period, 6);
        @(negedge clk);
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        meas_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid", meas_valid, 1);
        chk("t6_period", meas_period, 8);
        chk("t6_high", meas_high, exp_high(3));
        chk("t6_overrun", overrun, 0);
        meas_ready = 1'b0;
        drive(1'b0, 4);

        // randomized period sequences with random duty
        repeat (3) begin
            do_reset();
            meas_ready = 1'b1;
            mon_en     = 1'b1;
            repeat (8) begin
                p    = $urandom_range(2, 14);
                reps = $urandom_range(1, 5);
                repeat (reps) begin
                    h = $urandom_range(1, p - 1);
                    gen_period(h, p - h);
                end
            end
            gen_period(1, 1);
            drive(1'b0, 6);
            chk("rnd_drain", exp_q.size(), 0);
            chk("rnd_overrun", overrun, 0);
            mon_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side companion to the ripple clock divider: measures a square-wave input (a divided clock, e.g. clk_div2..clk_div16) against the system clock.
- Synchronises the input, times rising-edge to rising-edge in clk cycles, and tracks frequency lock.
- Each period measurement is presented on a valid/ready output with a one-entry holding register.
- Used on-chip as a self-check of divider outputs and as a generic frequency monitor.

Parameters:
- CNT_W, 16, width of period/high-time counters and outputs.
- LOCK_COUNT, 4, consecutive identical periods required to assert locked (min 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sig_in  input  1  measured signal, asynchronous to clk
- meas_valid  output  1  measurement held and available
- meas_ready  input  1  consumer accepts measurement
- meas_period  output  CNT_W  period in clk cycles
- meas_high  output  CNT_W  high-time in clk cycles (see Optional Feature)
- locked  output  1  period stable for LOCK_COUNT periods
- no_signal  output  1  no rising edge for 2^CNT_W-1 cycles
- overrun  output  1  sticky, a measurement was dropped

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. Outputs meas_valid=0, meas_period=0, meas_high=0, locked=0, no_signal=0, overrun=0. Synchroniser flops 0, state IDLE, cnt=0, match count=0.
- Input path: 2-flop synchroniser gives s. Edge register gives rise = s & ~s_d. Latency from sig_in rising to rise is 3 clk cycles.
- Counter cnt: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at all-ones. A period of P clk cycles is captured as P; minimum measurable period is 2.
- State IDLE: waits for the first rise; on rise goes to RUN and emits nothing. If cnt saturates first, goes to TIMEOUT.
- State RUN: on each rise, a measurement {period=cnt, high=hi_cnt} is produced. If cnt saturates, goes to TIMEOUT, clears locked and match count, emits nothing.
- State TIMEOUT: no_signal=1. On rise, no_signal clears the next cycle, state goes to RUN, nothing is emitted.
- Lock tracking, per produced measurement:
  - Period equal to the previous produced period: match<=min(match+1, LOCK_COUNT).
  - Otherwise: match<=1.
  - locked = (match==LOCK_COUNT); it updates in the same cycle as the measurement register, including on dropped measurements.
- Output handshake:
  - Transfer occurs when meas_valid & meas_ready. meas_period and meas_high stay stable while meas_valid=1 and no transfer occurs.
  - Measurement produced with meas_valid=0, or in the same cycle as a transfer: loaded, meas_valid=1 next cycle.
  - Measurement produced with meas_valid=1 & !meas_ready: dropped, held data unchanged, overrun<=1. overrun stays set until reset.
  - Transfer with no new measurement: meas_valid<=0.
- Reset asserted mid-operation: all state returns to reset values the next cycle; a pending measurement is discarded.

Optional Feature:
- Macro PERIOD_METER_DUTY_EN.
- Defined: hi_cnt counts cycles with s=1 since the last rise, resets on rise and saturates. meas_high carries the captured hi_cnt.
- Undefined: no hi_cnt logic; meas_high is tied to 0. The port is still present so the interface is identical in both builds.

Decomposition:
- Package clk_period_meter_pkg: state enum (IDLE, RUN, TIMEOUT) and the synchroniser depth constant (2).
- One sub-module, sync_edge_det: 2-flop synchroniser plus rising-edge pulse, reusable elsewhere.
- Counters, FSM, lock logic and handshake register stay in the top module.

Test Plan:
- sig_in = clk/4 (2 high, 2 low), meas_ready=1: first measurement has meas_period=4, meas_high=2 (0 when the macro is undefined). locked rises with the 4th measurement; overrun stays 0.
- sig_in = clk/16, meas_ready=0 after the first measurement: held meas_period=16 stays stable, and overrun=1 after the next rise. Raising meas_ready then transfers 16 and meas_valid drops when no new measurement arrives.
- Locked at period 8, then a single stretched period of 10: the measurement of 10 clears locked in its update cycle. Re-lock requires 4 consecutive identical periods at the new period.
- sig_in stuck low with CNT_W=8: no_signal=1 and locked=0 after cnt saturates at 255. Restarting clk/2 clears no_signal; the first emitted measurement after that is 2.
- Reset asserted for 1 cycle while meas_valid=1 and locked=1: the next cycle shows all outputs 0. The first rise after reset emits nothing and the second emits a measurement.
- Measurement produced in the same cycle as a transfer: the new value is loaded, meas_valid stays 1, and overrun stays 0.
